// File: rtl/multicycle_core.sv
// Multicycle register machine: one instruction walks FETCH/DECODE/EXEC/(MEM)/(WB)
// with req/ack handshakes on separate instruction and data memory ports.
module multicycle_core #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 4,
  parameter int PC_W = 8,
  localparam int INSTR_W = 4 + 3 * REG_AW
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic [PC_W-1:0]    pc,
  output logic               halted
);
  localparam int NREG = 1 << REG_AW;
  localparam logic [PC_W-1:0]   PC_ZERO = {PC_W{1'b0}};
  localparam logic [PC_W-1:0]   PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] D_ZERO  = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] D_ONE   = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [REG_AW-1:0] R_ZERO  = {REG_AW{1'b0}};

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SLT = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_LI  = 4'd6;
  localparam logic [3:0] OP_LW  = 4'd8;
  localparam logic [3:0] OP_SW  = 4'd9;
  localparam logic [3:0] OP_BEQ = 4'd10;
  localparam logic [3:0] OP_JMP = 4'd11;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [DATA_W-1:0]   rf_q [NREG];
  logic                rf_we_s;
  logic                op_valid_s;

  logic [3:0]          op_s;
  logic [REG_AW-1:0]   rs_s, rt_s, rd_s;
  logic [DATA_W-1:0]   rs_val_s, rt_val_s, rd_val_s;
  logic [PC_W-1:0]     pc_inc_s, br_off_s, jmp_tgt_s;

  assign op_s = ir_q[INSTR_W-1 -: 4];
  assign rs_s = ir_q[3*REG_AW-1 -: REG_AW];
  assign rt_s = ir_q[2*REG_AW-1 -: REG_AW];
  assign rd_s = ir_q[REG_AW-1:0];

  // R0 is hard-wired to zero on every read port
  assign rs_val_s = (rs_s == R_ZERO) ? D_ZERO : rf_q[rs_s];
  assign rt_val_s = (rt_s == R_ZERO) ? D_ZERO : rf_q[rt_s];
  assign rd_val_s = (rd_s == R_ZERO) ? D_ZERO : rf_q[rd_s];

  assign pc_inc_s  = pc_q + PC_ONE;
  assign br_off_s  = PC_W'({{PC_W{rd_s[REG_AW-1]}}, rd_s});
  assign jmp_tgt_s = PC_W'({rt_s, rd_s});

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign halted     = (state_q == S_HALT);
  assign dmem_addr  = a_q;
  assign dmem_wdata = rd_val_s;

  always_comb begin
    op_valid_s = 1'b0;
    case (op_s)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_XOR, OP_LI,
      OP_LW, OP_SW, OP_BEQ, OP_JMP: op_valid_s = 1'b1;
      default: op_valid_s = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    rf_we_s  = 1'b0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    case (state_q)
      S_FETCH: begin
        // Reset parks the FSM in FETCH, so the request is masked while rst is high
        imem_req = ~rst;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        a_d = rs_val_s;
        b_d = rt_val_s;
        if (op_valid_s) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_HALT;
        end
      end
      S_EXEC: begin
        case (op_s)
          OP_ADD: begin res_d = a_q + b_q; state_d = S_WB; end
          OP_SUB: begin res_d = a_q - b_q; state_d = S_WB; end
          OP_AND: begin res_d = a_q & b_q; state_d = S_WB; end
          OP_OR:  begin res_d = a_q | b_q; state_d = S_WB; end
          OP_SLT: begin res_d = (a_q < b_q) ? D_ONE : D_ZERO; state_d = S_WB; end
          OP_XOR: begin res_d = a_q ^ b_q; state_d = S_WB; end
          OP_LI:  begin res_d = DATA_W'({{DATA_W{1'b0}}, rt_s}); state_d = S_WB; end
          OP_LW, OP_SW: state_d = S_MEM;
          OP_BEQ: begin
            pc_d    = (a_q == b_q) ? (pc_inc_s + br_off_s) : pc_inc_s;
            state_d = S_FETCH;
          end
          OP_JMP: begin pc_d = jmp_tgt_s; state_d = S_FETCH; end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_s == OP_SW);
        if (dmem_ack) begin
          // Stores retire here; loads still need a write-back cycle
          if (op_s == OP_SW) begin
            pc_d    = pc_inc_s;
            state_d = S_FETCH;
          end else begin
            res_d   = dmem_rdata;
            state_d = S_WB;
          end
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB: begin
        rf_we_s = 1'b1;
        pc_d    = pc_inc_s;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= PC_ZERO;
      ir_q    <= {INSTR_W{1'b0}};
      a_q     <= D_ZERO;
      b_q     <= D_ZERO;
      res_q   <= D_ZERO;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= D_ZERO;
      end
    end else if (rf_we_s && (rd_s != R_ZERO)) begin
      rf_q[rd_s] <= res_q;
    end
  end
endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: directed programs plus random forward-only programs,
// all checked against an instruction-level model with a latency table.
module tb_multicycle_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  pc;
  logic        halted;

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] imem [256];
  logic [7:0]  dmem [256];
  int idelay = 0;
  int ddelay = 0;
  bit track = 1'b0;
  int exp_fetch[$];
  int exp_store[$];
  int exp_regs [16];
  int exp_pc, exp_cycles;

  multicycle_core #(.DATA_W(8), .REG_AW(4), .PC_W(8)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc(pc), .halted(halted)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int rs, input int rt, input int rd);
    return {op[3:0], rs[3:0], rt[3:0], rd[3:0]};
  endfunction

  // Instruction memory: ack after idelay wait cycles, checks fetch order and stability
  initial begin : imem_resp
    int w;
    int e;
    logic [7:0] a0;
    w = 0;
    imem_ack = 1'b0;
    imem_rdata = 16'h0000;
    a0 = 8'h00;
    forever begin
      @(negedge clk);
      imem_ack = 1'b0;
      if (imem_req === 1'b1) begin
        if (w == 0) a0 = imem_addr;
        else chk("imem_addr_stable", imem_addr, a0);
        if (w >= idelay) begin
          imem_ack = 1'b1;
          imem_rdata = imem[imem_addr];
          if (track) begin
            if (exp_fetch.size() > 0) e = exp_fetch.pop_front();
            else e = -1;
            chk("fetch_addr", imem_addr, e);
          end
          w = 0;
        end else begin
          w++;
        end
      end else begin
        w = 0;
      end
    end
  end

  // Data memory: ack after ddelay wait cycles, checks hold length, stability, store stream
  initial begin : dmem_resp
    int w, len, e;
    logic [7:0] a0, d0;
    logic we0;
    w = 0; len = 0;
    a0 = 8'h00; d0 = 8'h00; we0 = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      dmem_ack = 1'b0;
      if (dmem_req === 1'b1) begin
        if (len == 0) begin
          a0 = dmem_addr; d0 = dmem_wdata; we0 = dmem_we;
        end else begin
          chk("dmem_addr_stable", dmem_addr, a0);
          chk("dmem_we_stable", dmem_we, we0);
          if (we0) chk("dmem_wdata_stable", dmem_wdata, d0);
        end
        len++;
        if (w >= ddelay) begin
          dmem_ack = 1'b1;
          if (dmem_we) begin
            dmem[dmem_addr] = dmem_wdata;
            if (track) begin
              if (exp_store.size() > 0) e = exp_store.pop_front();
              else e = -1;
              chk("store_addr_data", {dmem_addr, dmem_wdata}, e);
            end
          end else begin
            dmem_rdata = dmem[dmem_addr];
          end
          chk("dmem_req_cycles", len, ddelay + 1);
          w = 0; len = 0;
        end else begin
          w++;
        end
      end else begin
        w = 0; len = 0;
      end
    end
  end

  // ISA-level reference: architectural effect plus cycle cost of each instruction
  task automatic run_model();
    int p, op, rs, rt, rd, a, b, res, off, steps;
    bit wr, done;
    logic [15:0] ins;
    int md [256];
    for (int i = 0; i < 256; i++) md[i] = int'(dmem[i]);
    for (int i = 0; i < 16; i++) exp_regs[i] = 0;
    exp_fetch.delete();
    exp_store.delete();
    p = 0; exp_cycles = 0; done = 1'b0; steps = 0;
    while (!done && steps < 2000) begin
      steps++;
      ins = imem[p];
      exp_fetch.push_back(p);
      op = int'(ins[15:12]); rs = int'(ins[11:8]); rt = int'(ins[7:4]); rd = int'(ins[3:0]);
      a = exp_regs[rs]; b = exp_regs[rt];
      wr = 1'b0; res = 0;
      exp_cycles += idelay;
      case (op)
        0: begin res = a + b; wr = 1'b1; end
        1: begin res = a - b; wr = 1'b1; end
        2: begin res = a & b; wr = 1'b1; end
        3: begin res = a | b; wr = 1'b1; end
        4: begin res = (a < b) ? 1 : 0; wr = 1'b1; end
        5: begin res = a ^ b; wr = 1'b1; end
        6: begin res = rt; wr = 1'b1; end
        8: begin res = md[a]; wr = 1'b1; exp_cycles += 1 + ddelay; end
        9: begin
          md[a] = exp_regs[rd];
          exp_store.push_back(a * 256 + exp_regs[rd]);
          exp_cycles += 4 + ddelay;
          p = (p + 1) % 256;
        end
        10: begin
          off = (rd >= 8) ? rd - 16 : rd;
          p = (a == b) ? (p + 1 + off + 256) % 256 : (p + 1) % 256;
          exp_cycles += 3;
        end
        11: begin p = rt * 16 + rd; exp_cycles += 3; end
        default: begin done = 1'b1; exp_cycles += 3; end
      endcase
      if (wr) begin
        if (rd != 0) exp_regs[rd] = res & 255;
        p = (p + 1) % 256;
        exp_cycles += 4;
      end
    end
    exp_pc = p;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
  endtask

  task automatic rand_dmem();
    for (int i = 0; i < 256; i++) dmem[i] = 8'($urandom_range(0, 255));
  endtask

  // Halt is first visible in the last cycle of the HLT's 3-cycle slot
  task automatic run_prog(input string name, input int id, input int dd, output int cyc);
    idelay = id;
    ddelay = dd;
    rst = 1'b1;
    @(posedge clk);
    run_model();
    track = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (halted !== 1'b1 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_halt_cycle"}, cyc, exp_cycles - 1);
    chk({name, "_pc"}, pc, exp_pc);
    for (int i = 0; i < 16; i++) chk({name, "_reg"}, dut.rf_q[i], exp_regs[i]);
    chk({name, "_fetches_left"}, exp_fetch.size(), 0);
    chk({name, "_stores_left"}, exp_store.size(), 0);
    repeat (4) begin
      @(negedge clk);
      chk({name, "_halt_no_ireq"}, imem_req, 1'b0);
      chk({name, "_halt_pc_frozen"}, pc, exp_pc);
      chk({name, "_halted"}, halted, 1'b1);
    end
    track = 1'b0;
  endtask

  task automatic gen_random(input int len);
    int ops [11] = '{0, 1, 2, 3, 4, 5, 6, 8, 9, 10, 11};
    int op, rd, t;
    clear_imem();
    for (int i = 0; i < len - 1; i++) begin
      op = ops[$urandom_range(0, 10)];
      if (op == 10) begin
        rd = $urandom_range(0, 3);
        if (rd > len - 2 - i) rd = len - 2 - i;
        imem[i] = enc(op, $urandom_range(0, 15), $urandom_range(0, 15), rd);
      end else if (op == 11) begin
        t = i + 1 + $urandom_range(0, 2);
        if (t > len - 1) t = len - 1;
        imem[i] = enc(op, 0, t / 16, t % 16);
      end else begin
        imem[i] = enc(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      end
    end
    imem[len - 1] = 16'hF000;
  endtask

  initial begin : main
    int cyc;
    logic [7:0] saved;
    clear_imem();
    rand_dmem();

    // Reset state while rst is held
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_dmem_req", dmem_req, 1'b0);
    chk("rst_dmem_we", dmem_we, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_pc", pc, 8'h00);

    // LI R1,5; LI R2,3; ADD R3,R1,R2; HLT with zero-wait memory
    clear_imem();
    imem[0] = enc(6, 0, 5, 1);
    imem[1] = enc(6, 0, 3, 2);
    imem[2] = enc(0, 1, 2, 3);
    run_prog("basic", 0, 0, cyc);
    chk("basic_cycles_const", cyc, 14);
    chk("basic_pc_const", pc, 8'd3);
    chk("basic_r3_const", dut.rf_q[3], 8'd8);

    // Modulo arithmetic: 0-1 = 255, 255+1 = 0, unsigned SLT
    clear_imem();
    imem[0] = enc(6, 0, 1, 1);
    imem[1] = enc(1, 0, 1, 2);
    imem[2] = enc(0, 2, 1, 3);
    imem[3] = enc(4, 1, 2, 4);
    run_prog("wrap", 1, 0, cyc);
    chk("wrap_r2", dut.rf_q[2], 8'd255);
    chk("wrap_r3", dut.rf_q[3], 8'd0);
    chk("wrap_slt", dut.rf_q[4], 8'd1);

    // SW then LW through the same address with 3 wait cycles per access
    clear_imem();
    imem[0] = enc(6, 0, 7, 1);
    imem[1] = enc(6, 0, 9, 2);
    imem[2] = enc(9, 1, 0, 2);
    imem[3] = enc(8, 1, 0, 4);
    run_prog("swlw", 0, 3, cyc);
    chk("swlw_r4", dut.rf_q[4], 8'd9);
    chk("swlw_mem", dmem[7], 8'd9);

    // BEQ taken at pc=5 with offset -2 lands on 4; not taken lands on 6
    clear_imem();
    imem[0] = enc(6, 0, 1, 1);
    imem[1] = enc(6, 0, 1, 2);
    imem[2] = enc(11, 0, 0, 5);
    imem[5] = enc(10, 1, 2, 14);
    run_prog("beq_taken", 0, 0, cyc);
    chk("beq_taken_pc", pc, 8'd4);
    imem[5] = enc(10, 1, 3, 14);
    run_prog("beq_not", 2, 0, cyc);
    chk("beq_not_pc", pc, 8'd6);

    // JMP to 0xFF, LI write-back there wraps pc to 0, then BEQ falls to HLT at 1
    clear_imem();
    imem[0]   = enc(10, 5, 0, 1);
    imem[2]   = enc(11, 0, 15, 15);
    imem[255] = enc(6, 0, 7, 5);
    run_prog("jmp_wrap", 0, 0, cyc);
    chk("jmp_wrap_pc", pc, 8'd1);
    chk("jmp_wrap_r5", dut.rf_q[5], 8'd7);

    // Write to R0 discarded, then undefined opcode 12 halts
    clear_imem();
    dmem[3] = 8'hAA;
    imem[0] = enc(6, 0, 3, 1);
    imem[1] = enc(6, 0, 4, 2);
    imem[2] = enc(0, 1, 2, 0);
    imem[3] = enc(9, 1, 0, 0);
    imem[4] = enc(12, 0, 0, 0);
    run_prog("r0_undef", 0, 1, cyc);
    chk("r0_store_zero", dmem[3], 8'd0);
    chk("r0_undef_pc", pc, 8'd4);

    // Random forward-only programs with random wait states
    for (int k = 0; k < 8; k++) begin
      rand_dmem();
      gen_random(24);
      run_prog("rand", $urandom_range(0, 2), $urandom_range(0, 2), cyc);
    end

    // Reset in the middle of a store: request drops at once, fetch of 0 follows release
    clear_imem();
    imem[0] = enc(6, 0, 2, 1);
    imem[1] = enc(9, 1, 0, 1);
    dmem[2] = 8'h5A;
    saved = dmem[2];
    idelay = 0;
    ddelay = 6;
    track = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
    while (dmem_req !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("midrst_mem_reached", dmem_req, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_dmem_req", dmem_req, 1'b0);
    chk("midrst_dmem_we", dmem_we, 1'b0);
    chk("midrst_pc", pc, 8'h00);
    chk("midrst_imem_req", imem_req, 1'b0);
    chk("midrst_halted", halted, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_fetch_req", imem_req, 1'b1);
    chk("midrst_fetch_addr", imem_addr, 8'h00);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_store_abandoned", dmem[2], saved);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_core.md
MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 Parameter DATA_W, default 8, datapath and register width in bits (legal 4..32).
REQ-002 Parameter REG_AW, default 4, register-address width; register file holds 2^REG_AW registers.
REQ-003 Parameter PC_W, default 8, program-counter and instruction-address width (PC_W <= 2*REG_AW).
REQ-004 Derived INSTR_W = 4 + 3*REG_AW; instruction = {op[3:0], rs, rt, rd}, each field REG_AW bits.
REQ-005 clk  in  1  clock, all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 imem_req  out  1  instruction fetch request.
REQ-008 imem_addr  out  PC_W  fetch address.
REQ-009 imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
REQ-010 imem_rdata  in  INSTR_W  fetched instruction.
REQ-011 dmem_req  out  1  data access request.
REQ-012 dmem_we  out  1  1 = store, 0 = load; valid while dmem_req=1.
REQ-013 dmem_addr  out  DATA_W  data address.
REQ-014 dmem_wdata  out  DATA_W  store data.
REQ-015 dmem_ack  in  1  data access complete; dmem_rdata valid this cycle on load.
REQ-016 dmem_rdata  in  DATA_W  load data.
REQ-017 pc  out  PC_W  current PC.
REQ-018 halted  out  1  core in HALT state.

Function
REQ-019 FSM states FETCH, DECODE, EXEC, MEM, WB, HALT; exactly one state per cycle.
REQ-020 FETCH: imem_req=1, imem_addr=pc; stay until imem_ack=1, then latch imem_rdata into IR, go DECODE.
REQ-021 DECODE: latch A=R[rs], B=R[rt] into operand registers; go EXEC (or HALT on opcode 15 or undefined opcode).
REQ-022 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT (unsigned, result 1/0), 5 XOR: rd <= A op B, EXEC->WB.
REQ-023 Opcode 6 LI: rd <= zero-extended {rt} (REG_AW bits), EXEC->WB.
REQ-024 Opcode 8 LW: dmem_addr=A, EXEC->MEM; MEM holds dmem_req=1, dmem_we=0 until dmem_ack, latches dmem_rdata, ->WB.
REQ-025 Opcode 9 SW: dmem_addr=A, dmem_wdata=R[rd]; MEM holds dmem_req=1, dmem_we=1 until dmem_ack, ->FETCH (no WB).
REQ-026 Opcode 10 BEQ: if A==B, pc <= pc + 1 + sign-extended rd field, else pc <= pc + 1; EXEC->FETCH.
REQ-027 Opcode 11 JMP: pc <= low PC_W bits of {rt,rd}; EXEC->FETCH.
REQ-028 Opcodes 7, 12-14 undefined -> HALT; 15 HLT -> HALT.
REQ-029 WB: write result to R[rd], pc <= pc + 1, ->FETCH; PC updates exactly once per instruction.
REQ-030 All arithmetic modulo 2^DATA_W; PC arithmetic modulo 2^PC_W (0xFF+1 wraps to 0 at default).
REQ-031 R0 reads as 0; writes to R0 discarded.
REQ-032 Request/address/data outputs stable from assertion until ack cycle; req deasserts the cycle after ack.
REQ-033 imem_ack/dmem_ack while corresponding req=0 ignored.
REQ-034 HALT: no requests, pc frozen, halted=1; exited only by rst.
REQ-035 Latency with zero-wait memory (ack same cycle as req): ALU/LI 4 cycles, LW 5, SW 4, BEQ/JMP 3.

Reset
REQ-036 rst=1 forces immediately: state FETCH, pc=0, IR=0, all registers 0, imem_req=0 while rst high, dmem_req=0, dmem_we=0, halted=0.
REQ-037 rst mid-access abandons the transaction; first fetch of address 0 starts the first clock after rst deasserts.

Verification
REQ-038 Program LI R1,5; LI R2,3; ADD R3,R1,R2; HLT with zero-wait memory -> R3=8, halted=1 after 4+4+4+3 cycles, pc=3.
REQ-039 LI R1,15; LI R2,1; ADD R3,R1,R2 repeated until R3 overflows at DATA_W=4 -> 15+1 yields R3=0.
REQ-040 SW R2 to address R1 then LW R4 from R1, dmem_ack delayed 3 cycles each -> dmem_req held 4 cycles, addr/data stable, R4 equals R2.
REQ-041 BEQ taken with rd=-2 at pc=5 -> pc=4; not taken -> pc=6; JMP {rt,rd}=0xFF at PC_W=8 then WB -> pc wraps to 0.
REQ-042 ADD R0,R1,R2 -> R0 reads 0; opcode 12 -> halted=1, no further imem_req.
REQ-043 rst pulsed during MEM with dmem_req=1 -> dmem_req drops asynchronously, pc=0, next cycle after release imem_req=1, imem_addr=0.
